// File: rtl/fetch_unit.sv
// Triangle fetch engine: reads nine vertex coordinate words and one color word
// over a single-outstanding request/grant/rvalid port and commits them atomically.
module fetch_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int COORD_WIDTH = 16,
    parameter int COLOR_WIDTH = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   fetch_start,
    input  logic [ADDR_WIDTH-1:0]                  curr_addr_vertex,
    input  logic [ADDR_WIDTH-1:0]                  curr_addr_color,
    output logic [2:0][2:0][COORD_WIDTH-1:0]       fetch_vertexes,
    output logic [COLOR_WIDTH-1:0]                 fetch_color,
    output logic                                   fetch_eoc,
    output logic                                   fetch_overrun,
    output logic                                   mem_req,
    output logic [ADDR_WIDTH-1:0]                  mem_addr,
    input  logic                                   mem_gnt,
    input  logic                                   mem_rvalid,
    input  logic [COORD_WIDTH-1:0]                 mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                  state_reg;
    logic [3:0]              k_reg;
    logic [ADDR_WIDTH-1:0]   vbase_reg;
    logic [ADDR_WIDTH-1:0]   cbase_reg;
    logic                    mem_req_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic                    eoc_reg;
    logic                    overrun_reg;
    logic [COORD_WIDTH-1:0]  shadow_reg [0:8];
    logic [COORD_WIDTH-1:0]  vert_reg   [0:8];
    logic [COLOR_WIDTH-1:0]  color_reg;
    logic [ADDR_WIDTH-1:0]   addr_next;

    // Address of word k+1: the color word follows the ninth coordinate.
    always_comb begin
        addr_next = vbase_reg + ADDR_WIDTH'({k_reg + 4'd1, 1'b0});
        if (k_reg == 4'd8) begin
            addr_next = cbase_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            k_reg        <= 4'd0;
            vbase_reg    <= '0;
            cbase_reg    <= '0;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
            eoc_reg      <= 1'b1;
            overrun_reg  <= 1'b0;
            color_reg    <= '0;
            for (int i = 0; i < 9; i++) begin
                shadow_reg[i] <= '0;
                vert_reg[i]   <= '0;
            end
        end else begin
            if (fetch_start && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (fetch_start) begin
                        state_reg    <= REQ;
                        k_reg        <= 4'd0;
                        vbase_reg    <= curr_addr_vertex;
                        cbase_reg    <= curr_addr_color;
                        mem_req_reg  <= 1'b1;
                        mem_addr_reg <= curr_addr_vertex;
                        eoc_reg      <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state_reg    <= WAIT;
                        mem_req_reg  <= 1'b0;
                        mem_addr_reg <= '0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (k_reg == 4'd9) begin
                            // Final word: publish the whole triangle in one edge.
                            state_reg <= IDLE;
                            eoc_reg   <= 1'b1;
                            color_reg <= mem_rdata;
                            for (int i = 0; i < 9; i++) begin
                                vert_reg[i] <= shadow_reg[i];
                            end
                        end else begin
                            state_reg         <= REQ;
                            shadow_reg[k_reg] <= mem_rdata;
                            k_reg             <= k_reg + 4'd1;
                            mem_req_reg       <= 1'b1;
                            mem_addr_reg      <= addr_next;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_vert
            assign fetch_vertexes[gi / 3][gi % 3] = vert_reg[gi];
        end
    endgenerate

    assign fetch_color   = color_reg;
    assign fetch_eoc     = eoc_reg;
    assign fetch_overrun = overrun_reg;
    assign mem_req       = mem_req_reg;
    assign mem_addr      = mem_addr_reg;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, byte address width; COORD_WIDTH, 16, coordinate width; COLOR_WIDTH, 16, color width; the memory word width SHALL equal COORD_WIDTH and SHALL equal COLOR_WIDTH.
REQ-002 Ports SHALL be, one per line, in this order:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- fetch_start  in  1  one-cycle pulse, start fetch of one triangle
- curr_addr_vertex  in  ADDR_WIDTH  byte address of first vertex coordinate word
- curr_addr_color  in  ADDR_WIDTH  byte address of color word
- fetch_vertexes  out  [3][3] x COORD_WIDTH  vertex i, coordinate j (x,y,z)
- fetch_color  out  COLOR_WIDTH  triangle color
- fetch_eoc  out  1  level: outputs valid, unit idle
- fetch_overrun  out  1  sticky: fetch_start seen while busy
- mem_req  out  1  read request valid
- mem_addr  out  ADDR_WIDTH  read byte address
- mem_gnt  in  1  request accepted this cycle when mem_req=1
- mem_rvalid  in  1  read data valid
- mem_rdata  in  COORD_WIDTH  read data
REQ-003 The block SHALL have one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 One triangle SHALL be 10 word reads: word k=0..8 to fetch_vertexes[k/3][k%3] at address curr_addr_vertex + 2*k; word k=9 to fetch_color at curr_addr_color.
REQ-005 Address arithmetic SHALL be ADDR_WIDTH bits, modulo 2^ADDR_WIDTH (wrap-around allowed, no flag).
REQ-006 curr_addr_vertex and curr_addr_color SHALL be captured on the fetch_start cycle; later changes SHALL not affect the running fetch.
REQ-007 State machine SHALL have states IDLE, REQ, WAIT: IDLE->REQ on fetch_start (k cleared); REQ->WAIT when mem_gnt=1; WAIT->REQ on mem_rvalid with k<9 (k increments); WAIT->IDLE on mem_rvalid with k=9.
REQ-008 mem_req SHALL be 1 only in REQ; mem_addr SHALL be held stable while mem_req=1 and mem_gnt=0; mem_addr SHALL be 0 outside REQ.
REQ-009 At most one read SHALL be outstanding; mem_rvalid outside WAIT SHALL be ignored.
REQ-010 Received words SHALL be assembled in a shadow buffer; fetch_vertexes and fetch_color SHALL update all together, only on the WAIT->IDLE edge, and SHALL stay stable otherwise.
REQ-011 fetch_eoc SHALL be 1 in IDLE, 0 in REQ/WAIT; it SHALL fall in the cycle after fetch_start and rise together with the output commit.
REQ-012 With mem_gnt tied 1 and mem_rvalid one cycle after grant, fetch_eoc SHALL rise 21 cycles after the fetch_start cycle (word k granted in cycle 1+2k, returned in cycle 2+2k).
REQ-013 fetch_start while not IDLE SHALL be ignored and SHALL set fetch_overrun, which stays 1 until reset.
REQ-014 fetch_start in the same cycle as the final mem_rvalid SHALL be treated as busy (ignored, overrun set).

Reset
REQ-015 With reset=1 at a clock edge: state IDLE, k=0, fetch_eoc=1, fetch_overrun=0, mem_req=0, mem_addr=0, fetch_vertexes all 0, fetch_color=0, shadow buffer cleared.
REQ-016 Reset mid-fetch SHALL abandon the fetch with no output commit; a mem_rvalid arriving after reset SHALL be ignored.
REQ-017 Reset SHALL take priority over fetch_start in the same cycle.

Verification
REQ-018 Reset, then idle -> fetch_eoc=1, mem_req=0, all outputs 0, fetch_overrun=0.
REQ-019 vertex addr 0x1000, color addr 0x2000, zero-wait memory returning addr[15:0] -> addresses 0x1000..0x1010 step 2 then 0x2000; fetch_vertexes[2][1]=0x100E, fetch_color=0x2000; fetch_eoc rises 21 cycles after start.
REQ-020 mem_gnt held 0 for 3 cycles on word 4 and rvalid delayed 2 cycles -> mem_addr steady at base+8 during stall, outputs unchanged until final word, fetch_eoc rises 26 cycles after start.
REQ-021 fetch_start pulsed at cycle 5 of a fetch and in the final-rvalid cycle -> fetch ignored both times, fetch_overrun=1 and sticky, result matches single fetch.
REQ-022 vertex addr 0xFFFFFFFC -> addresses 0xFFFFFFFC, 0xFFFFFFFE, 0x00000000, ... 0x0000000C wrap correctly.
REQ-023 reset asserted at cycle 8 of a fetch, stray mem_rvalid next cycle -> outputs stay 0, fetch_eoc=1, new fetch afterwards completes normally.
